// File: rtl/swerv_types.sv
// Shared trigger types: the packet driven into the decode PC-match datapath,
// the stored per-trigger tdata1 fields, and the tdata1 bit map / CSR address codes.
package swerv_types;
    localparam int NTRIG = 4;
    localparam int TDW   = 64;

    typedef struct packed {
        logic           select;
        logic           match;
        logic           execute;
        logic           m;
        logic [TDW-1:0] tdata2;
    } trigger_pkt_t;

    typedef struct packed {
        logic dmode;
        logic hit;
        logic select;
        logic action;
        logic chain;
        logic match;
        logic m;
        logic execute;
    } trig_cfg_t;

    typedef enum logic {TRIG_IDLE, TRIG_PEND} trig_state_t;

    localparam logic [3:0] TDATA1_TYPE = 4'd2;
    localparam int T1_TYPE_LSB = 60;
    localparam int T1_DMODE    = 59;
    localparam int T1_HIT      = 20;
    localparam int T1_SELECT   = 19;
    localparam int T1_ACTION   = 12;
    localparam int T1_CHAIN    = 11;
    localparam int T1_MATCH    = 7;
    localparam int T1_M        = 6;
    localparam int T1_EXECUTE  = 2;

    localparam logic [1:0] CSR_TSELECT = 2'd0;
    localparam logic [1:0] CSR_TDATA1  = 2'd1;
    localparam logic [1:0] CSR_TDATA2  = 2'd2;

    function automatic logic [TDW-1:0] tdata1_pack(input trig_cfg_t c);
        logic [TDW-1:0] r;
        r = '0;
        r[T1_TYPE_LSB +: 4] = TDATA1_TYPE;
        r[T1_DMODE]   = c.dmode;
        r[T1_HIT]     = c.hit;
        r[T1_SELECT]  = c.select;
        r[T1_ACTION]  = c.action;
        r[T1_CHAIN]   = c.chain;
        r[T1_MATCH]   = c.match;
        r[T1_M]       = c.m;
        r[T1_EXECUTE] = c.execute;
        return r;
    endfunction
endpackage

// File: rtl/dec_trig_chain.sv
// Per-slot trigger resolution: gate raw matches with slot valid, then apply
// pairwise chaining on (0,1) and (2,3).
module dec_trig_chain
    import swerv_types::*;
(
    input  logic [NTRIG-1:0]   match,
    input  logic               valid,
    input  logic [NTRIG/2-1:0] pair_chain,
    output logic [NTRIG-1:0]   fired
);
    logic [NTRIG-1:0] raw;

    assign raw = match & {NTRIG{valid}};

    for (genvar k = 0; k < NTRIG/2; k++) begin : g_pair
        logic both;
        assign both = raw[2*k] & raw[2*k+1];
        // a chained pair fires as a unit or not at all
        assign fired[2*k+1:2*k] = pair_chain[k] ? {2{both}} : raw[2*k+1:2*k];
    end
endmodule

// File: rtl/dec_trigger_ctl.sv
// Debug trigger CSRs, trigger packet to the PC-match datapath, and the
// hit-capture / TLU request handshake.
module dec_trigger_ctl
    import swerv_types::*;
(
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     csr_wr_en,
    input  logic [1:0]               csr_wr_addr,
    input  logic [TDW-1:0]           csr_wr_data,
    input  logic [1:0]               csr_rd_addr,
    output logic [TDW-1:0]           csr_rd_data,
    input  logic                     dbg_mode,
    output trigger_pkt_t [NTRIG-1:0] trigger_pkt_any,
    input  logic [NTRIG-1:0]         i0_trigger_match_d,
    input  logic [NTRIG-1:0]         i1_trigger_match_d,
    input  logic                     i0_valid_d,
    input  logic                     i1_valid_d,
    output logic                     trig_req,
    output logic                     trig_action,
    output logic                     trig_slot,
    output logic [NTRIG-1:0]         trig_fired,
    input  logic                     trig_ack
);
    trig_state_t                   state_q, state_d;
    logic [1:0]                    tselect_q, tselect_d;
    trig_cfg_t [NTRIG-1:0]         cfg_q, cfg_d;
    logic [NTRIG-1:0][TDW-1:0]     tdata2_q, tdata2_d;
    trigger_pkt_t [NTRIG-1:0]      pkt_q, pkt_d;
    logic                          action_q, action_d;
    logic                          slot_q, slot_d;
    logic [NTRIG-1:0]              fired_q, fired_d;

    logic [NTRIG/2-1:0] pair_chain;
    logic [NTRIG-1:0]   action_vec;
    logic [NTRIG-1:0]   fired_i0, fired_i1, fired_sel;
    logic               capture;
    logic               wr_blocked;
    logic               new_dmode;

    always_comb begin
        pair_chain = '0;
        action_vec = '0;
        for (int k = 0; k < NTRIG/2; k++) pair_chain[k] = cfg_q[2*k].chain;
        for (int i = 0; i < NTRIG; i++) action_vec[i] = cfg_q[i].action;
    end

    dec_trig_chain u_chain_i0 (
        .match      (i0_trigger_match_d),
        .valid      (i0_valid_d),
        .pair_chain (pair_chain),
        .fired      (fired_i0)
    );

    dec_trig_chain u_chain_i1 (
        .match      (i1_trigger_match_d),
        .valid      (i1_valid_d),
        .pair_chain (pair_chain),
        .fired      (fired_i1)
    );

    // i0 is older; any i0 fire hides i1 for this cycle
    assign fired_sel = (|fired_i0) ? fired_i0 : fired_i1;

    always_comb begin
        state_d  = state_q;
        action_d = action_q;
        slot_d   = slot_q;
        fired_d  = fired_q;
        capture  = 1'b0;
        case (state_q)
            TRIG_IDLE: begin
                if ((|fired_sel) && !dbg_mode) begin
                    capture  = 1'b1;
                    state_d  = TRIG_PEND;
                    slot_d   = ~(|fired_i0);
                    fired_d  = fired_sel;
                    action_d = |(fired_sel & action_vec);
                end
            end
            TRIG_PEND: begin
                if (trig_ack) state_d = TRIG_IDLE;
            end
            default: state_d = TRIG_IDLE;
        endcase
    end

    assign wr_blocked = cfg_q[tselect_q].dmode & ~dbg_mode;

    always_comb begin
        tselect_d = tselect_q;
        cfg_d     = cfg_q;
        tdata2_d  = tdata2_q;
        new_dmode = cfg_q[tselect_q].dmode;
        if (csr_wr_en) begin
            case (csr_wr_addr)
                CSR_TSELECT: tselect_d = csr_wr_data[1:0];
                CSR_TDATA1: begin
                    if (!wr_blocked) begin
                        if (dbg_mode) new_dmode = csr_wr_data[T1_DMODE];
                        cfg_d[tselect_q].dmode   = new_dmode;
                        cfg_d[tselect_q].hit     = csr_wr_data[T1_HIT];
                        cfg_d[tselect_q].select  = csr_wr_data[T1_SELECT];
                        cfg_d[tselect_q].action  = csr_wr_data[T1_ACTION] & new_dmode;
                        cfg_d[tselect_q].chain   = csr_wr_data[T1_CHAIN] & ~tselect_q[0];
                        cfg_d[tselect_q].match   = csr_wr_data[T1_MATCH];
                        cfg_d[tselect_q].m       = csr_wr_data[T1_M];
                        cfg_d[tselect_q].execute = csr_wr_data[T1_EXECUTE];
                    end
                end
                CSR_TDATA2: if (!wr_blocked) tdata2_d[tselect_q] = csr_wr_data;
                default: ;
            endcase
        end
        // hit capture is applied after the write so a set is never lost
        for (int i = 0; i < NTRIG; i++)
            cfg_d[i].hit = cfg_d[i].hit | (capture & fired_sel[i]);
    end

    always_comb begin
        pkt_d = '0;
        for (int i = 0; i < NTRIG; i++) begin
            pkt_d[i].select  = cfg_d[i].select;
            pkt_d[i].match   = cfg_d[i].match;
            pkt_d[i].execute = cfg_d[i].execute & ~dbg_mode;
            pkt_d[i].m       = cfg_d[i].m;
            pkt_d[i].tdata2  = tdata2_d[i];
        end
    end

    always_comb begin
        case (csr_rd_addr)
            CSR_TSELECT: csr_rd_data = {{(TDW-2){1'b0}}, tselect_q};
            CSR_TDATA1:  csr_rd_data = tdata1_pack(cfg_q[tselect_q]);
            CSR_TDATA2:  csr_rd_data = tdata2_q[tselect_q];
            default:     csr_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= TRIG_IDLE;
            tselect_q <= '0;
            cfg_q     <= '0;
            tdata2_q  <= '0;
            pkt_q     <= '0;
            action_q  <= 1'b0;
            slot_q    <= 1'b0;
            fired_q   <= '0;
        end else begin
            state_q   <= state_d;
            tselect_q <= tselect_d;
            cfg_q     <= cfg_d;
            tdata2_q  <= tdata2_d;
            pkt_q     <= pkt_d;
            action_q  <= action_d;
            slot_q    <= slot_d;
            fired_q   <= fired_d;
        end
    end

    assign trigger_pkt_any = pkt_q;
    assign trig_req        = (state_q == TRIG_PEND);
    assign trig_action     = action_q;
    assign trig_slot       = slot_q;
    assign trig_fired      = fired_q;
endmodule

// File: tb/tb_dec_trigger_ctl.sv
// Scoreboard bench for dec_trigger_ctl: directed cases plus a random match
// phase checked against a field-level model of the trigger CSRs.
module tb_dec_trigger_ctl;
    import swerv_types::*;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic csr_wr_en = 1'b0;
    logic [1:0] csr_wr_addr = '0;
    logic [63:0] csr_wr_data = '0;
    logic [1:0] csr_rd_addr = '0;
    logic [63:0] csr_rd_data;
    logic dbg_mode = 1'b0;
    trigger_pkt_t [NTRIG-1:0] pkt;
    logic [3:0] i0_m = '0, i1_m = '0;
    logic i0_v = 1'b0, i1_v = 1'b0;
    logic trig_req, trig_action, trig_slot, trig_ack = 1'b0;
    logic [3:0] trig_fired;

    dec_trigger_ctl dut (
        .clk(clk), .rst_l(rst_l),
        .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
        .dbg_mode(dbg_mode), .trigger_pkt_any(pkt),
        .i0_trigger_match_d(i0_m), .i1_trigger_match_d(i1_m),
        .i0_valid_d(i0_v), .i1_valid_d(i1_v),
        .trig_req(trig_req), .trig_action(trig_action), .trig_slot(trig_slot),
        .trig_fired(trig_fired), .trig_ack(trig_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: tdata1 held as its architectural readback value
    localparam logic [63:0] T1_MASK  = 64'h0800_0000_0018_18C4;
    localparam logic [63:0] T1_RESET = 64'h2000_0000_0000_0000;
    logic [63:0] m_t1 [4];
    logic [63:0] m_t2 [4];
    logic [1:0]  m_tsel;
    bit          busy;

    typedef struct {
        logic [3:0] fired;
        logic       slot;
        logic       action;
        int         cyc;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_t1[i] = T1_RESET;
            m_t2[i] = '0;
        end
        m_tsel = '0;
        busy = 0;
    endfunction

    function automatic logic [3:0] resolve(input logic [3:0] m, input logic v);
        logic [3:0] r;
        logic b;
        r = v ? m : 4'b0;
        for (int k = 0; k < 2; k++)
            if (m_t1[2*k][11]) begin
                b = r[2*k] & r[2*k+1];
                r[2*k] = b;
                r[2*k+1] = b;
            end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        logic [63:0] nv;
        csr_wr_en = 1'b1;
        csr_wr_addr = a;
        csr_wr_data = d;
        if (a == 2'd0) m_tsel = d[1:0];
        else if (!(m_t1[m_tsel][59] && !dbg_mode)) begin
            if (a == 2'd1) begin
                nv = d & T1_MASK;
                if (!dbg_mode) nv[59] = m_t1[m_tsel][59];
                if (m_tsel[0]) nv[11] = 1'b0;
                if (!nv[59]) nv[12] = 1'b0;
                nv[63:60] = 4'd2;
                m_t1[m_tsel] = nv;
            end else if (a == 2'd2) begin
                m_t2[m_tsel] = d;
            end
        end
        step();
        csr_wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [63:0] exp);
        csr_rd_addr = a;
        #1;
        chk(name, csr_rd_data, exp);
    endtask

    task automatic drive(input logic [3:0] m0, input logic [3:0] m1,
                         input logic v0, input logic v1, input logic ack);
        logic [3:0] f0, f1, f;
        logic cap, act;
        exp_t e;
        i0_m = m0; i1_m = m1; i0_v = v0; i1_v = v1; trig_ack = ack;
        f0 = resolve(m0, v0);
        f1 = resolve(m1, v1);
        f = (f0 != 4'b0) ? f0 : f1;
        cap = !busy && (f != 4'b0) && !dbg_mode;
        act = 1'b0;
        for (int i = 0; i < 4; i++) if (f[i] && m_t1[i][12]) act = 1'b1;
        step();
        if (busy && ack) busy = 0;
        if (cap) begin
            e.fired = f; e.slot = (f0 == 4'b0); e.action = act; e.cyc = cyc;
            sbq.push_back(e);
            busy = 1;
            for (int i = 0; i < 4; i++) if (f[i]) m_t1[i][20] = 1'b1;
        end
        i0_m = '0; i1_m = '0; i0_v = 1'b0; i1_v = 1'b0; trig_ack = 1'b0;
    endtask

    // monitor: request level every cycle, scoreboard pop on each new request
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_l) prev = 1'b0;
            else begin
                chk("req_level", trig_req, busy);
                if (trig_req && !prev) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req got fired=%b exp=no request", trig_fired);
                    end else begin
                        e = sbq.pop_front();
                        chk("req_fired", trig_fired, e.fired);
                        chk("req_slot", trig_slot, e.slot);
                        chk("req_action", trig_action, e.action);
                        chk("req_cycle", cyc, e.cyc);
                    end
                end
                prev = trig_req;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (3) step();
        rd_chk("rst_tdata1", 2'd1, 64'h2000_0000_0000_0000);
        chk("rst_pkt", 64'(pkt != '0), 64'd0);
        chk("rst_req", trig_req, 1'b0);
        rst_l = 1'b1;
        step();

        // basic execute trigger on slot i0
        wr(2'd0, 64'd0);
        wr(2'd1, 64'h44);
        wr(2'd2, 64'h8000_0100);
        chk("pkt0_exec", pkt[0].execute, 1'b1);
        chk("pkt0_tdata2", pkt[0].tdata2, 64'h8000_0100);
        drive(4'b0001, 4'b0, 1'b1, 1'b0, 1'b0);
        chk("basic_req", trig_req, 1'b1);
        chk("basic_fired", trig_fired, 4'b0001);
        rd_chk("basic_hit", 2'd1, 64'h2000_0000_0010_0044);
        drive(4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_ack", trig_req, 1'b0);

        // chained pair (0,1)
        wr(2'd1, 64'h844);
        rd_chk("chain_rd", 2'd1, 64'h2000_0000_0000_0844);
        drive(4'b0001, 4'b0, 1'b1, 1'b0, 1'b0);
        chk("chain_half", trig_req, 1'b0);
        drive(4'b0011, 4'b0, 1'b1, 1'b0, 1'b0);
        chk("chain_both", trig_fired, 4'b0011);
        drive(4'b0, 4'b0, 1'b0, 1'b0, 1'b1);

        // i0 priority over i1
        drive(4'b0100, 4'b1000, 1'b1, 1'b1, 1'b0);
        chk("prio_slot", trig_slot, 1'b0);
        chk("prio_fired", trig_fired, 4'b0100);
        drive(4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        wr(2'd0, 64'd3);
        rd_chk("prio_hit3", 2'd1, 64'h2000_0000_0000_0000);
        wr(2'd0, 64'd2);
        rd_chk("prio_hit2", 2'd1, 64'h2000_0000_0010_0000);

        // dmode / action WARL
        wr(2'd0, 64'd1);
        wr(2'd1, 64'h0800_0000_0000_1004);
        rd_chk("dmode_nodbg", 2'd1, 64'h2000_0000_0000_0004);
        dbg_mode = 1'b1;
        wr(2'd1, 64'h0800_0000_0000_1004);
        rd_chk("dmode_dbg", 2'd1, 64'h2800_0000_0000_1004);
        chk("pkt_exec_dbg", pkt[1].execute, 1'b0);
        dbg_mode = 1'b0;
        wr(2'd1, 64'd0);
        rd_chk("dmode_drop", 2'd1, 64'h2800_0000_0000_1004);
        wr(2'd2, 64'd5);
        rd_chk("tdata2_drop", 2'd2, 64'd0);
        chk("pkt_exec_nodbg", pkt[1].execute, 1'b1);

        // async reset while pending
        wr(2'd0, 64'd0);
        drive(4'b0011, 4'b0, 1'b1, 1'b0, 1'b0);
        chk("pend_req", trig_req, 1'b1);
        rst_l = 1'b0;
        #1;
        chk("rst_in_pend", trig_req, 1'b0);
        m_reset();
        sbq.delete();
        step();
        step();
        rst_l = 1'b1;
        step();
        wr(2'd1, 64'h44);
        drive(4'b0001, 4'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_req", trig_req, 1'b1);
        drive(4'b0, 4'b0, 1'b0, 1'b0, 1'b1);

        // random configuration and match traffic
        for (int i = 0; i < 4; i++) begin
            dbg_mode = ($urandom_range(0, 3) == 0);
            wr(2'd0, 64'(i));
            wr(2'd1, {$urandom, $urandom});
            wr(2'd2, {$urandom, $urandom});
        end
        for (int n = 0; n < 400; n++) begin
            dbg_mode = ($urandom_range(0, 9) == 0);
            drive(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0));
        end
        dbg_mode = 1'b0;
        for (int n = 0; n < 20 && busy; n++) drive(4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("drain_idle", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            wr(2'd0, 64'(i));
            rd_chk("rand_tdata1", 2'd1, m_t1[i]);
            rd_chk("rand_tdata2", 2'd2, m_t2[i]);
            chk("rand_pkt", {pkt[i].select, pkt[i].match, pkt[i].execute, pkt[i].m},
                {m_t1[i][19], m_t1[i][7], m_t1[i][2], m_t1[i][6]});
            chk("rand_pkt_t2", pkt[i].tdata2, m_t2[i]);
        end
        step();
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dec_trigger_ctl.md
Name: dec_trigger_ctl

Overview:
- Owns the four debug trigger CSR sets (tselect/tdata1/tdata2) and drives the registered trigger_pkt_any[3:0] into the decode-stage PC-match datapath.
- Takes back that datapath's per-slot match vectors and resolves chaining and i0/i1 priority.
- Latches hit bits and issues one breakpoint-exception or debug-entry request to the TLU over a req/ack handshake.

Parameters:
- NTRIG, 4, number of triggers; fixed at 4, chain pairs are (0,1) and (2,3).
- TDW, 64, tdata2 width.

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset; asynchronous assert, active-low
- csr_wr_en  in  1  CSR write strobe
- csr_wr_addr  in  2  write target: 0 tselect, 1 tdata1, 2 tdata2
- csr_wr_data  in  64  write data
- csr_rd_addr  in  2  read select, same encoding as csr_wr_addr
- csr_rd_data  out  64  combinational read data for the selected trigger
- dbg_mode  in  1  core is in debug mode
- trigger_pkt_any  out  trigger_pkt_t[3:0]  registered config to the match datapath
- i0_trigger_match_d  in  4  per-trigger raw match for slot i0
- i1_trigger_match_d  in  4  per-trigger raw match for slot i1
- i0_valid_d  in  1  slot i0 holds a valid instruction
- i1_valid_d  in  1  slot i1 holds a valid instruction
- trig_req  out  1  trigger action request to the TLU
- trig_action  out  1  0 = breakpoint exception, 1 = enter debug
- trig_slot  out  1  0 = i0, 1 = i1
- trig_fired  out  4  triggers responsible for the request
- trig_ack  in  1  TLU has taken the request

Behaviour:
- tdata1 layout:
  - [63:60] type, reads 2
  - [59] dmode
  - [20] hit
  - [19] select
  - [12] action
  - [11] chain
  - [7] match
  - [6] m
  - [2] execute
  - all other bits read 0
- tselect is 2 bits and reads zero-extended.
- WARL rules:
  - chain is writable only on triggers 0 and 2; triggers 1 and 3 read 0.
  - action is stored as written & dmode.
  - dmode is writable only when dbg_mode=1.
  - A tdata1/tdata2 write to a trigger whose stored dmode=1 while dbg_mode=0 is dropped.
- Reset state:
  - All tdata1/tdata2 fields 0, tselect 0, FSM IDLE.
  - trig_req=0, trig_action=0, trig_slot=0, trig_fired=0.
  - trigger_pkt_any all 0.
- trigger_pkt_any[i]:
  - Registered copy of trigger i's fields.
  - Updated the cycle after the CSR write.
  - execute is forced 0 while dbg_mode=1.
- Per-slot resolution, combinational, done for i0 and i1:
  - raw = match & {4{valid}}.
  - Pair (2k, 2k+1) with chain[2k]=1: both fire only if both raw bits are set; otherwise neither fires.
  - Pair with chain[2k]=0: each trigger fires independently.
- Priority: if i0 fires any trigger, i1 results are discarded for that cycle.
- FSM states:
  - IDLE -> PEND when any slot fires and dbg_mode=0. On this transition:
    - capture trig_slot, trig_fired, and trig_action = OR over fired triggers of action;
    - set hit[i] for every fired trigger.
  - PEND: trig_req=1; outputs held stable.
  - PEND -> IDLE on trig_ack; trig_req deasserts the following cycle.
  - Fires while in PEND are ignored and set no hit bits.
- Latency: match in cycle N -> trig_req=1 in cycle N+1.
- Same-cycle hit capture and tdata1 write to that trigger: the write data is applied, then the hit bit is ORed in; hit sets win.
- Software clears hit by writing tdata1.hit=0 in a cycle with no capture.
- Async reset in PEND returns the FSM to IDLE with trig_req=0 immediately.
- trig_ack while IDLE is ignored.

Decomposition:
- swerv_types holds:
  - existing trigger_pkt_t;
  - new localparams for the tdata1 bit positions, TDATA1_TYPE=4'd2, and the CSR address codes.
- One sub-module, dec_trig_chain: combinational per-slot chain and valid resolution, returning a 4-bit fired vector. Instantiated twice (i0, i1).

Test Plan:
- Reset, then read tdata1 -> 64'h2000_0000_0000_0000; trigger_pkt_any all 0; trig_req=0.
- tselect=0; tdata1 = execute|m (action=0); tdata2=64'h8000_0100; pulse i0_trigger_match_d=4'b0001 with i0_valid_d=1 in cycle N:
  - cycle N+1: trig_req=1, trig_action=0, trig_slot=0, trig_fired=4'b0001, tdata1[0].hit=1;
  - after trig_ack, trig_req=0.
- chain[0]=1 with match=4'b0001 -> no req; match=4'b0011 -> trig_fired=4'b0011.
- i0 match 4'b0100 and i1 match 4'b1000 in the same cycle -> trig_slot=0, trig_fired=4'b0100, hit[3] stays 0.
- Write dmode=1, action=1 with dbg_mode=0 -> readback dmode=0, action=0. The same write with dbg_mode=1 sticks. A later write with dbg_mode=0 is dropped.
- Drop rst_l while in PEND -> trig_req=0 immediately; after release, a new match is accepted normally.
